// File: rtl/pipeline_elastic_reg.sv
// Elastic inter-stage pipeline register: valid/ready handshake with a two-entry
// skid buffer, synchronous flush, bubble control gating and a stall counter.
module pipeline_elastic_reg #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_count
);

    // State encoding doubles as the entry count, so occupancy is a direct copy.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   main_data_q, main_data_d;
    logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;
    logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
    logic [CNT_W-1:0]    stall_q, stall_d;
    logic                accept_s;
    logic                consume_s;

    // Handshake flags come only from state and port inputs; in_ready never sees out_ready.
    assign in_ready    = (state_q != ST_TWO);
    assign out_valid   = (state_q != ST_EMPTY);
    assign occupancy   = state_q;
    assign out_data    = main_data_q;
    assign out_ctrl    = out_valid ? main_ctrl_q : {CTRL_W{1'b0}};
    assign stall_count = stall_q;
    assign accept_s    = in_valid & in_ready;
    assign consume_s   = out_valid & out_ready;

    // Next-state, payload movement and stall counting.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        stall_d     = stall_q;

        if (out_valid && !out_ready && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + CNT_W'(1);
        end else begin
            stall_d = stall_q;
        end

        if (reset) begin
            state_d     = ST_EMPTY;
            main_data_d = {DATA_W{1'b0}};
            main_ctrl_d = {CTRL_W{1'b0}};
            skid_data_d = {DATA_W{1'b0}};
            skid_ctrl_d = {CTRL_W{1'b0}};
            stall_d     = {CNT_W{1'b0}};
        end else if (flush) begin
            // Squash drops held entries and any same-cycle accept; payloads may stay stale.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_s) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                        state_d     = ST_ONE;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && consume_s) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                        state_d     = ST_ONE;
                    end else if (accept_s) begin
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                        state_d     = ST_TWO;
                    end else if (consume_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (consume_s) begin
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                        state_d     = ST_ONE;
                    end else begin
                        state_d = ST_TWO;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State and payload registers.
    always_ff @(posedge CLK) begin
        state_q     <= state_d;
        main_data_q <= main_data_d;
        main_ctrl_q <= main_ctrl_d;
        skid_data_q <= skid_data_d;
        skid_ctrl_q <= skid_ctrl_d;
        stall_q     <= stall_d;
    end

endmodule

// File: tb/tb_pipeline_elastic_reg.sv
// Randomised and directed bench for pipeline_elastic_reg against a queue-based
// reference model; a second instance with a 4-bit counter covers saturation.
module tb_pipeline_elastic_reg;

    localparam int DW = 128;
    localparam int CW = 16;

    logic          CLK = 1'b0;
    logic          reset, flush, in_valid, out_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;

    logic          in_ready_a, out_valid_a, in_ready_b, out_valid_b;
    logic [DW-1:0] out_data_a, out_data_b;
    logic [CW-1:0] out_ctrl_a, out_ctrl_b;
    logic [1:0]    occ_a, occ_b;
    logic [7:0]    stall_a;
    logic [3:0]    stall_b;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] md[$];
    logic [CW-1:0] mc[$];
    int            stall_m   = 0;
    bit            data_zero = 1'b0;

    always #5 CLK = ~CLK;

    pipeline_elastic_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(8)) dut_a (
        .CLK(CLK), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .out_ctrl(out_ctrl_a), .occupancy(occ_a), .stall_count(stall_a)
    );

    pipeline_elastic_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(4)) dut_b (
        .CLK(CLK), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .out_ctrl(out_ctrl_b), .occupancy(occ_b), .stall_count(stall_b)
    );

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        bit            v;
        logic [CW-1:0] ec;
        v  = (md.size() > 0);
        ec = v ? mc[0] : {CW{1'b0}};
        check_eq("in_ready",   in_ready_a,  md.size() < 2);
        check_eq("out_valid",  out_valid_a, v);
        check_eq("occupancy",  occ_a,       md.size());
        check_eq("out_ctrl",   out_ctrl_a,  ec);
        check_eq("stall8",     stall_a,     (stall_m > 255) ? 255 : stall_m);
        check_eq("b_occ",      occ_b,       md.size());
        check_eq("b_out_ctrl", out_ctrl_b,  ec);
        check_eq("stall4",     stall_b,     (stall_m > 15) ? 15 : stall_m);
        if (v) begin
            check_eq("out_data",   out_data_a, md[0]);
            check_eq("b_out_data", out_data_b, md[0]);
        end else if (data_zero) begin
            check_eq("out_data_rst", out_data_a, {DW{1'b0}});
        end
    endtask

    // One clock: drive inputs, advance the model, then compare after the edge.
    task automatic cyc(input bit v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input bit ordy, input bit fl, input bit rst);
        bit acc, con;
        reset = rst; flush = fl; in_valid = v; in_data = d; in_ctrl = c; out_ready = ordy;
        acc = v && (md.size() < 2);
        con = (md.size() > 0) && ordy;
        if ((md.size() > 0) && !ordy) stall_m++;
        if (rst) begin
            md.delete(); mc.delete(); stall_m = 0; data_zero = 1'b1;
        end else if (fl) begin
            md.delete(); mc.delete();
        end else begin
            if (con) begin
                void'(md.pop_front());
                void'(mc.pop_front());
            end
            if (acc) begin
                md.push_back(d); mc.push_back(c); data_zero = 1'b0;
            end
        end
        @(posedge CLK);
        #1;
        check_all();
    endtask

    initial begin
        logic [DW-1:0] rd;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_ctrl = '0;

        // Reset then stream 1..4 at full throughput
        cyc(1'b0, 128'd0, 16'h0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 128'd0, 16'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) cyc(1'b1, DW'(i), CW'(i), 1'b1, 1'b0, 1'b0);
        check_eq("stream_head", out_data_a, 128'd4);
        cyc(1'b0, 128'd0, 16'h0, 1'b1, 1'b0, 1'b0);

        // Backpressure fill, refused third entry, ordered drain
        cyc(1'b1, 128'hAA, 16'h0A, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 128'hBB, 16'h0B, 1'b0, 1'b0, 1'b0);
        check_eq("bp_occ2", occ_a, 128'd2);
        check_eq("bp_not_ready", in_ready_a, 128'd0);
        cyc(1'b1, 128'hCC, 16'h0C, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 128'hCC, 16'h0C, 1'b1, 1'b0, 1'b0);
        check_eq("bp_second", out_data_a, 128'hBB);
        cyc(1'b1, 128'hCC, 16'h0C, 1'b1, 1'b0, 1'b0);
        check_eq("bp_third", out_data_a, 128'hCC);
        cyc(1'b0, 128'd0, 16'h0, 1'b1, 1'b0, 1'b0);

        // Flush in TWO with a simultaneous offered entry
        cyc(1'b1, 128'h11, 16'h1111, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 128'h22, 16'h2222, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 128'h33, 16'hFFFF, 1'b0, 1'b1, 1'b0);
        check_eq("flush_occ", occ_a, 128'd0);
        check_eq("flush_ctrl", out_ctrl_a, 128'd0);

        // Bubble gating while empty
        for (int i = 0; i < 3; i++) cyc(1'b0, 128'h44, 16'hFFFF, 1'b1, 1'b0, 1'b0);

        // Reset mid-operation with 37 stall cycles counted
        cyc(1'b0, 128'd0, 16'h0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 128'h55, 16'h5555, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 128'h66, 16'h6666, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 36; i++) cyc(1'b0, 128'd0, 16'h0, 1'b0, 1'b0, 1'b0);
        check_eq("stall37", stall_a, 128'd37);
        check_eq("stall_sat", stall_b, 128'd15);
        cyc(1'b1, 128'h77, 16'h7777, 1'b1, 1'b0, 1'b1);
        check_eq("rst_valid", out_valid_a, 128'd0);
        check_eq("rst_ready", in_ready_a, 128'd1);
        check_eq("rst_stall", stall_a, 128'd0);

        // Saturation of the narrow counter over 20 held cycles
        cyc(1'b1, 128'h88, 16'h8888, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b0, 128'd0, 16'h0, 1'b0, 1'b0, 1'b0);
        check_eq("sat15", stall_b, 128'd15);
        check_eq("wide20", stall_a, 128'd20);

        // Randomised traffic with occasional flush and reset
        for (int i = 0; i < 400; i++) begin
            rd = {$urandom, $urandom, $urandom, $urandom};
            cyc(($urandom % 4) != 0, rd, CW'($urandom), ($urandom % 3) != 0,
                ($urandom % 32) == 0, ($urandom % 97) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_elastic_reg.md
Name: pipeline_elastic_reg

Overview:
- Parametrised successor to the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries one opaque data payload and one control payload between two pipeline stages.
- Replaces bare always-load behaviour with:
  - a valid/ready handshake,
  - a 2-entry skid buffer, so `in_ready` has no combinational path from `out_ready`,
  - synchronous flush for branch/jump squash,
  - control-bit gating on bubbles,
  - a saturating stall counter for performance monitoring.

Parameters:
- DATA_W, 128, width of datapath payload (pc, pc+4, operands, immediate, ...).
- CTRL_W, 16, width of control payload (alu op, selects, mem_write, mem_read, reg_write_en, ...).
- CNT_W, 8, width of the stall counter.

Ports:
- CLK  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high; highest priority.
- flush  input  1  synchronous squash of all held entries; priority below reset.
- in_valid  input  1  upstream presents a valid entry.
- in_ready  output  1  block can accept an entry this cycle.
- in_data  input  DATA_W  upstream datapath payload.
- in_ctrl  input  CTRL_W  upstream control payload.
- out_valid  output  1  `out_data`/`out_ctrl` hold a valid entry.
- out_ready  input  1  downstream consumes the entry this cycle.
- out_data  output  DATA_W  head-entry datapath payload.
- out_ctrl  output  CTRL_W  head-entry control payload; all zeros whenever `out_valid`=0.
- occupancy  output  2  entries held: 0, 1 or 2.
- stall_count  output  CNT_W  saturating count of backpressure cycles.

Behaviour:
- Handshake definitions:
  - Accept when `in_valid` && `in_ready` at the rising edge.
  - Consume when `out_valid` && `out_ready` at the rising edge.
- Storage: main register (head) and skid register.
- State machine:
  - States: EMPTY (occ 0), ONE (main full), TWO (main + skid full).
  - `in_ready` = (state != TWO), decoded from state registers only.
  - `out_valid` = (state != EMPTY).
- Transitions, evaluated when neither reset nor flush is asserted:
  - EMPTY, accept: main <= in → ONE.
  - EMPTY, no accept: stay EMPTY.
  - ONE, accept and consume: main <= in → stay ONE.
  - ONE, accept, no consume: skid <= in → TWO.
  - ONE, consume, no accept: → EMPTY.
  - ONE, neither: hold.
  - TWO, consume: main <= skid → ONE. No accept is possible in TWO.
  - TWO, no consume: hold both entries.
- Latency:
  - 1 cycle from accept to `out_valid` when EMPTY.
  - Strict FIFO order through skid; no entry is ever lost or duplicated.
  - Full throughput of 1 entry per cycle while `out_ready`=1.
- Payload gating:
  - `out_data` holds its stale value when invalid.
  - `out_ctrl` is forced to 0 when `out_valid`=0, so a bubble never asserts `mem_write` or `reg_write_en`.
- Flush:
  - Next state EMPTY; `out_ctrl` becomes 0.
  - Any simultaneous accept is dropped, since `in_ready` may read 1 but the entry is discarded.
  - Data registers are not required to clear.
- Reset (sync, from any state, including mid-transfer):
  - State EMPTY; `occupancy`=0; `out_valid`=0; `in_ready`=1 from the following cycle.
  - `out_data`=0; `out_ctrl`=0; `stall_count`=0.
  - Reset overrides flush and all handshakes.
- Stall counter:
  - Increments by 1 on every edge where `out_valid`=1 and `out_ready`=0.
  - Saturates at 2^CNT_W-1 and never wraps.
  - Cleared only by reset; flush does not clear it.
- No `#` delays anywhere.
- Widths are exact; no truncation between `in_*` and `out_*`.
- `occupancy` is encoded directly from state.

Test Plan:
- Reset then stream: reset for 2 cycles, then `in_valid`=1 with `in_data`=1,2,3,4 and `out_ready`=1 → `out_data` 1,2,3,4 on consecutive cycles starting 1 cycle after the first accept; `occupancy` stays 1; `stall_count`=0.
- Backpressure fill: `out_ready`=0, send A=0xAA then B=0xBB → after 2 edges `occupancy`=2 and `in_ready`=0. C=0xCC offered meanwhile is not accepted. Raise `out_ready` → out AA, BB, then CC in order; `stall_count` equals the cycles held with `out_valid`=1 and `out_ready`=0.
- Flush priority: in TWO, assert flush together with `in_valid` carrying `in_ctrl`=0xFFFF → next cycle `occupancy`=0, `out_valid`=0, `out_ctrl`=0x0000; the input entry never appears.
- Bubble gating: EMPTY state with `in_ctrl`=0xFFFF and `in_valid`=0 → `out_ctrl`=0x0000 and `out_valid`=0 for all cycles.
- Reset mid-operation: `occupancy`=2 and `stall_count`=37, assert reset together with `out_ready`=1 → next edge all outputs 0, `in_ready`=1, no entry emitted.
- Counter saturation: CNT_W=4, hold `out_valid`=1 and `out_ready`=0 for 20 cycles → `stall_count` reaches 15 and stays at 15.
